// File: rtl/stage_sequencer_if.sv
// Control/status bundle between a sequencer client and stage_sequencer.
// The client drives the run/step/stall/halt requests; the sequencer returns stage status.
interface stage_sequencer_if #(
    parameter int unsigned ICOUNT_W = 16
);
    logic                run;
    logic                step;
    logic                mem_wait;
    logic                halt_req;
    logic [2:0]          stage;
    logic                new_instr;
    logic                busy_c;
    logic                halted;
    logic [ICOUNT_W-1:0] instr_count;

    modport master (
        output run, step, mem_wait, halt_req,
        input  stage, new_instr, busy_c, halted, instr_count
    );

    modport slave (
        input  run, step, mem_wait, halt_req,
        output stage, new_instr, busy_c, halted, instr_count
    );
endinterface

// File: rtl/stage_sequencer.sv
// Five-stage instruction sequencer: walks fetch..write-back under run/step control,
// stalls fetch and memory on mem_wait, retires and counts instructions, and latches HALT.
module stage_sequencer #(
    parameter int unsigned ICOUNT_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    stage_sequencer_if.slave  bus
);

    localparam int unsigned STATE_W = 2;
    localparam int unsigned STAGE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] S_RUN    = 2'd1;
    localparam logic [STATE_W-1:0] S_STEP   = 2'd2;
    localparam logic [STATE_W-1:0] S_HALTED = 2'd3;

    localparam logic [STAGE_W-1:0] STG_NONE  = 3'd0;
    localparam logic [STAGE_W-1:0] STG_FETCH = 3'd1;
    localparam logic [STAGE_W-1:0] STG_DEC   = 3'd2;
    localparam logic [STAGE_W-1:0] STG_EXE   = 3'd3;
    localparam logic [STAGE_W-1:0] STG_MEM   = 3'd4;
    localparam logic [STAGE_W-1:0] STG_WB    = 3'd5;

    logic [STATE_W-1:0]  r_state;
    logic [STAGE_W-1:0]  r_stage;
    logic                r_new_instr;
    logic                r_halted;
    logic                r_halt_pending;
    logic                r_armed;
    logic [ICOUNT_W-1:0] r_instr_count;

    logic [STATE_W-1:0]  w_state_nxt;
    logic [STAGE_W-1:0]  w_stage_nxt;
    logic                w_pending_nxt;
    logic                w_retire;
    logic                w_halt_seen;

    // HALT is only meaningful once the instruction has been fetched (stages 2..5)
    assign w_halt_seen = bus.halt_req && (r_stage >= STG_DEC) && (r_stage <= STG_WB);

    // State register; r_armed holds off any fetch until the first edge after reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_stage        <= STG_NONE;
            r_new_instr    <= 1'b0;
            r_halted       <= 1'b0;
            r_halt_pending <= 1'b0;
            r_armed        <= 1'b0;
            r_instr_count  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_stage        <= w_stage_nxt;
            r_new_instr    <= (w_stage_nxt == STG_FETCH) && (r_stage != STG_FETCH);
            r_halted       <= (w_state_nxt == S_HALTED);
            r_halt_pending <= w_pending_nxt;
            r_armed        <= 1'b1;
            if (w_retire) begin
                r_instr_count <= r_instr_count + ICOUNT_W'(1);
            end
        end
    end

    // Next-state and stage-advance logic
    always_comb begin
        w_state_nxt   = r_state;
        w_stage_nxt   = r_stage;
        w_pending_nxt = r_halt_pending;
        w_retire      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_pending_nxt = 1'b0;
                if (r_armed) begin
                    if (bus.run) begin
                        w_state_nxt = S_RUN;
                        w_stage_nxt = STG_FETCH;
                    end else if (bus.step) begin
                        w_state_nxt = S_STEP;
                        w_stage_nxt = STG_FETCH;
                    end
                end
            end

            S_RUN, S_STEP: begin
                w_pending_nxt = r_halt_pending || w_halt_seen;
                case (r_stage)
                    STG_FETCH: if (!bus.mem_wait) w_stage_nxt = STG_DEC;
                    STG_DEC:   w_stage_nxt = STG_EXE;
                    STG_EXE:   w_stage_nxt = STG_MEM;
                    STG_MEM:   if (!bus.mem_wait) w_stage_nxt = STG_WB;
                    STG_WB: begin
                        // Retirement: halt beats single-step beats continued run
                        w_retire      = 1'b1;
                        w_pending_nxt = 1'b0;
                        if (r_halt_pending || w_halt_seen) begin
                            w_state_nxt = S_HALTED;
                            w_stage_nxt = STG_NONE;
                        end else if (r_state == S_STEP) begin
                            w_state_nxt = S_IDLE;
                            w_stage_nxt = STG_NONE;
                        end else if (bus.run) begin
                            w_stage_nxt = STG_FETCH;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_stage_nxt = STG_NONE;
                        end
                    end
                    default: begin
                        w_state_nxt   = S_IDLE;
                        w_stage_nxt   = STG_NONE;
                        w_pending_nxt = 1'b0;
                    end
                endcase
            end

            S_HALTED: begin
                w_stage_nxt   = STG_NONE;
                w_pending_nxt = 1'b0;
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_stage_nxt   = STG_NONE;
                w_pending_nxt = 1'b0;
            end
        endcase
    end

    assign bus.stage       = r_stage;
    assign bus.new_instr   = r_new_instr;
    assign bus.busy_c      = (r_stage != STG_NONE);
    assign bus.halted      = r_halted;
    assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: per-cycle expectations queued with each stimulus
// step and checked after the following clock edge.
module tb_stage_sequencer;

    localparam int unsigned CW = 2;

    typedef struct packed {
        logic [2:0]    stg;
        logic          ni;
        logic          hlt;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    exp_t sb_q[$];

    stage_sequencer_if #(.ICOUNT_W(CW)) bus ();

    stage_sequencer #(.ICOUNT_W(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        cmp({tag, ".stage"},  16'(bus.stage),       16'(e.stg));
        cmp({tag, ".new"},    16'(bus.new_instr),   16'(e.ni));
        cmp({tag, ".busy"},   16'(bus.busy_c),      16'(e.stg != 3'd0));
        cmp({tag, ".halted"}, 16'(bus.halted),      16'(e.hlt));
        cmp({tag, ".count"},  16'(bus.instr_count), 16'(e.cnt));
    endtask

    // Drive inputs for one cycle, queue the expected post-edge outputs, then check them
    task automatic cyc(input string tag, input logic run, input logic step, input logic mw,
                       input logic halt, input int stg, input logic ni, input logic hlt,
                       input int cnt);
        exp_t e;
        bus.run      = run;
        bus.step     = step;
        bus.mem_wait = mw;
        bus.halt_req = halt;
        e.stg = 3'(stg);
        e.ni  = ni;
        e.hlt = hlt;
        e.cnt = CW'(cnt);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            chk_all(tag, sb_q.pop_front());
        end
    endtask

    initial begin
        exp_t z;
        vectors      = 0;
        miscompares  = 0;
        z            = '0;
        rst_n        = 1'b0;
        bus.run      = 1'b0;
        bus.step     = 1'b0;
        bus.mem_wait = 1'b0;
        bus.halt_req = 1'b0;

        // Reset values, with Run/Step asserted during reset
        #3;
        chk_all("rst0", z);
        bus.run  = 1'b1;
        bus.step = 1'b1;
        @(posedge clk);
        #1;
        chk_all("rst_held", z);
        #2;
        rst_n = 1'b1;

        // First edge after reset only arms; fetch no earlier than the second edge
        cyc("arm", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++)
            cyc("run12", 1, 0, 0, 0, 1 + (i % 5), (i % 5) == 0, 0, i / 5);

        // Run dropped in stage 2: instruction still completes, then idle
        cyc("drop3", 0, 0, 0, 0, 3, 0, 0, 2);
        cyc("drop4", 0, 0, 0, 0, 4, 0, 0, 2);
        cyc("drop5", 0, 0, 0, 0, 5, 0, 0, 2);
        cyc("dropret", 0, 0, 0, 0, 0, 0, 0, 3);
        cyc("idle", 0, 0, 0, 0, 0, 0, 0, 3);

        // Stalls: 3 cycles in fetch, 2 in memory; mem_wait in 2/3/5 ignored; count wraps
        cyc("st_f0", 1, 0, 1, 0, 1, 1, 0, 3);
        cyc("st_f1", 1, 0, 1, 0, 1, 0, 0, 3);
        cyc("st_f2", 1, 0, 1, 0, 1, 0, 0, 3);
        cyc("st_f3", 1, 0, 1, 0, 1, 0, 0, 3);
        cyc("st_d",  1, 0, 0, 0, 2, 0, 0, 3);
        cyc("st_e",  1, 0, 1, 0, 3, 0, 0, 3);
        cyc("st_m0", 1, 0, 1, 0, 4, 0, 0, 3);
        cyc("st_m1", 1, 0, 1, 0, 4, 0, 0, 3);
        cyc("st_m2", 1, 0, 1, 0, 4, 0, 0, 3);
        cyc("st_wb", 1, 0, 0, 0, 5, 0, 0, 3);
        cyc("st_wrap", 0, 0, 1, 0, 0, 0, 0, 0);

        // Single step; a second Step during stage 3 is ignored
        cyc("stp1", 0, 1, 0, 0, 1, 1, 0, 0);
        cyc("stp2", 0, 0, 0, 0, 2, 0, 0, 0);
        cyc("stp3", 0, 0, 0, 0, 3, 0, 0, 0);
        cyc("stp4", 0, 1, 0, 0, 4, 0, 0, 0);
        cyc("stp5", 0, 0, 0, 0, 5, 0, 0, 0);
        cyc("stpret", 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("stpidle", 0, 0, 0, 0, 0, 0, 0, 1);

        // Run beats Step; Halt_Req in stage 1 ignored; back-to-back proves RUN
        cyc("pri1", 1, 1, 0, 0, 1, 1, 0, 1);
        cyc("pri2", 1, 0, 0, 1, 2, 0, 0, 1);
        cyc("pri3", 1, 0, 0, 0, 3, 0, 0, 1);
        cyc("pri4", 1, 0, 0, 0, 4, 0, 0, 1);
        cyc("pri5", 1, 0, 0, 0, 5, 0, 0, 1);
        cyc("b2b1", 1, 0, 0, 0, 1, 1, 0, 2);

        // Halt_Req pulsed in stage 2 -> finish, halt, ignore Run/Step afterwards
        cyc("h2", 1, 0, 0, 0, 2, 0, 0, 2);
        cyc("h3", 1, 0, 0, 1, 3, 0, 0, 2);
        cyc("h4", 1, 0, 0, 0, 4, 0, 0, 2);
        cyc("h5", 1, 0, 0, 0, 5, 0, 0, 2);
        cyc("hret", 1, 0, 0, 0, 0, 0, 1, 3);
        cyc("hrun", 1, 1, 0, 0, 0, 0, 1, 3);
        cyc("hstep", 0, 1, 0, 0, 0, 0, 1, 3);
        cyc("hidle", 0, 0, 0, 0, 0, 0, 1, 3);

        // Reset clears Halted asynchronously
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("hrst", z);
        #3;
        rst_n = 1'b1;
        cyc("arm2", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            cyc("pre_rst", 1, 0, 0, 0, 1 + (i % 5), (i % 5) == 0, 0, i / 5);

        // Asynchronous reset in stage 4: cleared before the next edge, nothing retired
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst", z);
        @(posedge clk);
        #1;
        chk_all("arst_edge", z);
        #2;
        rst_n = 1'b1;
        cyc("arm3", 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("quiet", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
